// File: rtl/pam4_pkg.sv
// Shared PAM-4 definitions: symbol type, Gray mapping and nominal level codes
// used by the TX packer, the level encoder and the RX slicer.
package pam4_pkg;

  localparam int PAM4_SYM_W = 2;

  typedef logic [PAM4_SYM_W-1:0] pam4_sym_t;

  localparam logic signed [7:0] PAM4_LVL_N3 = -8'sd84;
  localparam logic signed [7:0] PAM4_LVL_N1 = -8'sd28;
  localparam logic signed [7:0] PAM4_LVL_P1 = 8'sd28;
  localparam logic signed [7:0] PAM4_LVL_P3 = 8'sd84;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Gray coding keeps adjacent PAM-4 levels one bit apart.
  function automatic pam4_sym_t gray_enc(input pam4_sym_t b);
    return {b[1], b[1] ^ b[0]};
  endfunction

  function automatic pam4_sym_t gray_dec(input pam4_sym_t g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock FIFO with occupancy count; no write while full, reads from empty
// are ignored, and the read data is the current head entry (show-ahead).
module byte_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [LW-1:0]     level_q;
  logic              wr_fire;
  logic              rd_fire;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rptr_q];
  assign wr_fire   = wr_en_i && !full_o;
  assign rd_fire   = rd_en_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_fire) wptr_q <= wptr_q + AW'(1);
      if (rd_fire) rptr_q <= rptr_q + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pam4_symbol_packer.sv
// Byte-to-PAM-4 serializer: buffers bytes, splits each into four 2-bit symbols
// and emits one registered symbol/valid pulse per SYMBOL_PERIOD clocks.
module pam4_symbol_packer
  import pam4_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SYMBOL_PERIOD = 1,
  parameter int GRAY_EN       = 1,
  parameter int MSB_FIRST     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      byte_in,
  input  logic                            byte_in_valid,
  output logic                            byte_in_ready,
  input  logic                            enable,
  output logic [1:0]                      symbol_out,
  output logic                            symbol_out_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            busy
);

  localparam int CW = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;

  logic [0:0]    state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pam4_sym_t     sym_q, sym_d;
  logic          vld_q, vld_d;
  logic          pop;
  logic          tick;
  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;

  function automatic pam4_sym_t pick_sym(input logic [7:0] b, input logic [1:0] n);
    logic [1:0] pos;
    pos = (MSB_FIRST != 0) ? 2'd3 - n : n;
    return b[{pos, 1'b0} +: 2];
  endfunction

  function automatic pam4_sym_t map_sym(input pam4_sym_t s);
    return (GRAY_EN != 0) ? gray_enc(s) : s;
  endfunction

  byte_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (byte_in_valid),
    .wr_data_i (byte_in),
    .rd_en_i   (pop),
    .rd_data_o (fifo_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign tick = (cnt_q == '0);

  // Rate counter free-runs through byte boundaries so symbol spacing never stretches.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    vld_d   = 1'b0;
    pop     = 1'b0;
    if (enable) begin
      if (state_q == ST_IDLE) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          byte_d  = fifo_data;
          idx_d   = 2'd0;
          cnt_d   = '0;
          state_d = ST_EMIT;
        end
      end else begin
        cnt_d = (cnt_q == CW'(SYMBOL_PERIOD-1)) ? '0 : cnt_q + CW'(1);
        if (tick) begin
          sym_d = map_sym(pick_sym(byte_q, idx_q));
          vld_d = 1'b1;
          if (idx_q == 2'd3) begin
            if (!fifo_empty) begin
              pop    = 1'b1;
              byte_d = fifo_data;
              idx_d  = 2'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sym_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      vld_q   <= vld_d;
    end
  end

  assign byte_in_ready    = !fifo_full;
  assign symbol_out       = sym_q;
  assign symbol_out_valid = vld_q;
  assign busy             = (state_q == ST_EMIT) || (fifo_level != '0);

endmodule

// File: tb/tb_pam4_symbol_packer.sv
// Bench for pam4_symbol_packer: three parameter variants, a queue-based symbol
// stream model, directed timing cases and a randomized traffic phase.
module tb_pam4_symbol_packer;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bi  [NDUT];
  logic       bv  [NDUT];
  logic       en  [NDUT];
  logic       rdy [NDUT];
  logic [1:0] so  [NDUT];
  logic       sv  [NDUT];
  logic [2:0] lvl [NDUT];
  logic       bsy [NDUT];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cur     = 0;
  int push_edge = 0;
  int exp_q[$];
  int pulse_cyc[$];
  int last_sym [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pam4_symbol_packer #(.FIFO_DEPTH(4), .SYMBOL_PERIOD(1), .GRAY_EN(0), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .byte_in(bi[0]), .byte_in_valid(bv[0]), .byte_in_ready(rdy[0]),
    .enable(en[0]), .symbol_out(so[0]), .symbol_out_valid(sv[0]), .fifo_level(lvl[0]), .busy(bsy[0]));
  pam4_symbol_packer #(.FIFO_DEPTH(4), .SYMBOL_PERIOD(1), .GRAY_EN(1), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .byte_in(bi[1]), .byte_in_valid(bv[1]), .byte_in_ready(rdy[1]),
    .enable(en[1]), .symbol_out(so[1]), .symbol_out_valid(sv[1]), .fifo_level(lvl[1]), .busy(bsy[1]));
  pam4_symbol_packer #(.FIFO_DEPTH(4), .SYMBOL_PERIOD(3), .GRAY_EN(0), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .byte_in(bi[2]), .byte_in_valid(bv[2]), .byte_in_ready(rdy[2]),
    .enable(en[2]), .symbol_out(so[2]), .symbol_out_valid(sv[2]), .fifo_level(lvl[2]), .busy(bsy[2]));

  function automatic int gray_of(int k);  return (k == 1) ? 1 : 0; endfunction
  function automatic int msb_of(int k);   return (k != 2) ? 1 : 0; endfunction

  // Symbol n (in transmit order) of byte b for variant k.
  function automatic int exp_sym(int k, logic [7:0] b, int n);
    int gtab [4];
    int pos;
    int v;
    int raw;
    gtab = '{0, 1, 3, 2};
    pos  = (msb_of(k) != 0) ? 3 - n : n;
    v    = int'(b);
    raw  = (v >> (2 * pos)) & 3;
    return (gray_of(k) != 0) ? gtab[raw] : raw;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    if (obs !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  task automatic enqueue(input int k, input logic [7:0] b);
    for (int n = 0; n < 4; n++) exp_q.push_back(exp_sym(k, b, n));
  endtask

  task automatic push(input int k, input logic [7:0] b);
    int g;
    g = 0;
    bi[k] = b;
    bv[k] = 1'b1;
    while (!rdy[k] && g < 300) begin
      nx();
      g++;
    end
    check("push_ready", rdy[k], 1);
    if (rdy[k]) begin
      enqueue(k, b);
      push_edge = cyc + 1;
    end else begin
      bv[k] = 1'b0;
    end
    nx();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int g;
    g = 0;
    while (pulse_cyc.size() < n && g < budget) begin
      nx();
      g++;
    end
    check("pulse_count", pulse_cyc.size(), n);
  endtask

  task automatic chk_reset(input int k);
    check("rst_symbol", so[k], 0);
    check("rst_valid", sv[k], 0);
    check("rst_level", lvl[k], 0);
    check("rst_busy", bsy[k], 0);
    check("rst_ready", rdy[k], 1);
  endtask

  // Scoreboard: every pulse of the active variant must match the model stream.
  always @(negedge clk) begin
    int e;
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        last_sym[k] = 0;
      end else if (sv[k]) begin
        if (k != cur) check("stray_pulse", 1, 0);
        else if (exp_q.size() == 0) check("extra_pulse", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("symbol", so[k], e);
          last_sym[k] = e;
          pulse_cyc.push_back(cyc);
        end
      end else begin
        check("symbol_hold", so[k], last_sym[k]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    for (int k = 0; k < NDUT; k++) begin
      bi[k] = 8'h00;
      bv[k] = 1'b0;
      en[k] = 1'b1;
    end
    repeat (3) nx();
    for (int k = 0; k < NDUT; k++) chk_reset(k);
    rst = 1'b0;
    nx();

    // Basic order, natural binary, latency and busy release
    cur = 0; pulse_cyc.delete();
    push(0, 8'h1B); bv[0] = 1'b0;
    wait_pulses(4, 50);
    if (pulse_cyc.size() == 4) begin
      check("latency", pulse_cyc[0] - push_edge, 2);
      for (int i = 1; i < 4; i++) check("spacing_p1", pulse_cyc[i] - pulse_cyc[i-1], 1);
    end
    nx();
    check("busy_fall", bsy[0], 0);
    check("level_empty", lvl[0], 0);

    // Gray map
    cur = 1; pulse_cyc.delete();
    push(1, 8'h1B); bv[1] = 1'b0;
    wait_pulses(4, 50);
    nx();
    check("busy_fall_gray", bsy[1], 0);

    // Reversed order, period 3, back-to-back bytes
    cur = 2; pulse_cyc.delete();
    push(2, 8'hE4); push(2, 8'h1B); bv[2] = 1'b0;
    wait_pulses(8, 100);
    if (pulse_cyc.size() == 8) begin
      check("latency_p3", pulse_cyc[0] - (push_edge - 1), 2);
      for (int i = 1; i < 8; i++) check("spacing_p3", pulse_cyc[i] - pulse_cyc[i-1], 3);
    end
    nx();
    check("busy_fall_p3", bsy[2], 0);

    // Backpressure: fill while paused, fifth byte waits
    cur = 0; pulse_cyc.delete();
    en[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 8'($urandom));
    b = 8'($urandom);
    bi[0] = b; bv[0] = 1'b1;
    repeat (3) nx();
    check("bp_level", lvl[0], 4);
    check("bp_ready", rdy[0], 0);
    check("bp_busy", bsy[0], 1);
    check("bp_no_pulse", pulse_cyc.size(), 0);
    en[0] = 1'b1;
    push(0, b); bv[0] = 1'b0;
    wait_pulses(20, 200);
    nx();
    check("bp_drained", exp_q.size(), 0);

    // Pause after the second symbol
    pulse_cyc.delete();
    push(0, 8'h1B); bv[0] = 1'b0;
    wait_pulses(2, 50);
    en[0] = 1'b0;
    repeat (10) nx();
    check("pause_no_pulse", pulse_cyc.size(), 2);
    check("pause_busy", bsy[0], 1);
    en[0] = 1'b1;
    wait_pulses(4, 50);
    if (pulse_cyc.size() == 4) check("pause_resume_gap", pulse_cyc[2] - pulse_cyc[1], 11);

    // Reset mid-byte with two bytes queued
    pulse_cyc.delete();
    push(0, 8'($urandom)); push(0, 8'($urandom)); push(0, 8'($urandom)); bv[0] = 1'b0;
    wait_pulses(1, 20);
    check("pre_rst_level", lvl[0], 2);
    rst = 1'b1;
    nx();
    chk_reset(0);
    exp_q.delete();
    rst = 1'b0;
    repeat (20) nx();
    check("post_rst_silent", pulse_cyc.size(), 1);
    push(0, 8'hA5); bv[0] = 1'b0;
    wait_pulses(5, 50);

    // Randomized traffic with pauses and gaps on every variant
    for (int k = 0; k < NDUT; k++) begin
      cur = k; pulse_cyc.delete();
      repeat (10) nx();
      for (int i = 0; i < 40; i++) begin
        push(k, 8'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          bv[k] = 1'b0; en[k] = 1'b0;
          repeat ($urandom_range(1, 6)) nx();
          en[k] = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          bv[k] = 1'b0;
          repeat ($urandom_range(1, 3)) nx();
        end
      end
      bv[k] = 1'b0; en[k] = 1'b1;
      wait_pulses(160, 2000);
      nx();
      check("rand_drained", exp_q.size(), 0);
      check("rand_busy", bsy[k], 0);
      check("rand_level", lvl[k], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pam4_symbol_packer.md
Name: pam4_symbol_packer

Overview:
Upstream feeder for the PAM-4 level encoder in the TX simulation path. Accepts bytes (e.g. from the UART RX datapath) over a valid/ready handshake and buffers them in a small FIFO. Splits each byte into four 2-bit symbols and optionally Gray-codes them. Emits one symbol per SYMBOL_PERIOD cycles as a symbol/valid pulse pair that drives the encoder's symbol_in/symbol_in_valid directly.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; power of 2, ≥2
SYMBOL_PERIOD, 1, clk cycles between successive symbol_out_valid pulses; ≥1
GRAY_EN, 1, 1 = Gray-map each symbol before output; 0 = natural binary
MSB_FIRST, 1, 1 = send bits [7:6] first; 0 = send bits [1:0] first

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
byte_in  in  8  byte to serialize
byte_in_valid  in  1  byte_in is valid
byte_in_ready  out  1  FIFO can accept a byte; combinational, equal to !full
enable  in  1  allow symbol emission; 0 pauses the block at a symbol boundary
symbol_out  out  2  PAM-4 symbol, after the optional Gray mapping
symbol_out_valid  out  1  single-cycle pulse marking symbol_out
fifo_level  out  $clog2(FIFO_DEPTH+1)  number of bytes currently in the FIFO
busy  out  1  high while the serializer holds a byte or the FIFO is non-empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: symbol_out=0, symbol_out_valid=0, fifo_level=0, busy=0, byte_in_ready=1. FIFO pointers, shift register, symbol index and rate counter are all cleared.
- Reset asserted mid-byte: the partial byte and all FIFO contents are discarded. No further valid pulse occurs after the reset edge.
- Push: a byte is written when byte_in_valid && byte_in_ready at a clk edge.
- When full, ready stays low in that cycle even if a pop occurs in the same cycle; no same-cycle pass-through.
- Push and pop in the same cycle when not full: fifo_level is unchanged.
- Serializer FSM states:
  - IDLE: no byte held. If the FIFO is non-empty and enable=1, pop into the shift register, set index=0, go to EMIT.
  - EMIT: on a rate tick with enable=1, drive symbol[index] with valid=1 for one cycle, then index++.
  - After index 3 is emitted: if the FIFO is non-empty, pop the next byte and stay in EMIT; otherwise go to IDLE.
- Rate tick:
  - A counter counts 0..SYMBOL_PERIOD-1; a tick occurs when the counter is 0.
  - The counter restarts at 0 on entry to EMIT from IDLE.
  - While in EMIT it free-runs, including across byte boundaries, so spacing stays exactly SYMBOL_PERIOD with no gap between bytes.
- Latency: a byte pushed at edge N into an empty FIFO, with the FSM in IDLE and enable=1, produces its first symbol_out_valid after edge N+2.
  - With SYMBOL_PERIOD=1 the four symbols then follow on consecutive cycles.
- enable=0:
  - No pops and no valid pulses.
  - The rate counter and index hold their values.
  - Resuming continues with the next unsent symbol of the held byte, at the held counter phase.
- Symbol extraction:
  - MSB_FIRST=1 order: [7:6], [5:4], [3:2], [1:0].
  - MSB_FIRST=0 order: the reverse.
- Gray map (GRAY_EN=1): 00→00, 01→01, 10→11, 11→10. Adjacent PAM-4 levels therefore differ by one bit.
- symbol_out holds its last value between valid pulses.
- busy = (state==EMIT) || fifo_level!=0.

Decomposition:
- Package pam4_pkg:
  - PAM4_SYM_W=2.
  - Symbol typedef.
  - Gray encode and decode functions, shared with the future RX slicer.
  - PAM-4 level constants -84, -28, +28, +84 at 8-bit signed resolution, shared with the encoder and the slicer.
- Sub-module byte_sync_fifo:
  - Parameterized width and depth, synchronous active-high reset.
  - Outputs full, empty and level.
  - Reusable elsewhere in the UART path.

Test Plan:
- Basic order, natural binary: GRAY_EN=0, MSB_FIRST=1, SYMBOL_PERIOD=1, push 0x1B → symbols 00,01,10,11 on 4 consecutive cycles, first valid 2 cycles after the push edge; busy falls one cycle after the last symbol.
- Gray map and reversed order:
  - GRAY_EN=1, push 0x1B → symbols 00,01,11,10.
  - GRAY_EN=0, MSB_FIRST=0, push 0xE4 → symbols 00,01,10,11.
- Rate and back-to-back bytes: SYMBOL_PERIOD=3, push 0xE4 then 0x1B in consecutive cycles → 8 valid pulses exactly 3 cycles apart with no extra gap at the byte boundary; raw output 11,10,01,00,00,01,10,11.
- Backpressure: enable=0, push 5 bytes with valid held high → 4 accepted, fifo_level=4, ready=0 while the 5th is held. Raise enable → 20 symbols emitted, in order, with no loss or duplication.
- Pause mid-byte: SYMBOL_PERIOD=1, drop enable after the 2nd symbol of 0x1B for 10 cycles → no valid pulses during the pause; then 10,11 are emitted.
- Reset mid-byte: assert rst after the 1st symbol with 2 bytes queued → all outputs return to reset values on the next edge, fifo_level=0, and no pulse follows until a new push.
